star_cam_responder: RTL and testbench
=====================================

# star_cam_responder

Memory-side responder for the softmax datapath's CAM/SUB match-vector interface. It stores a table of DEPTH quantized keys and answers two request types. A CAM search request carries key `xi` and returns a one-hot-per-match vector. A subtract request carries two match vectors (x_max, x_i) and returns the match vector of key (x_max − x_i). The initiator sits on the other side of this interface and drives the requests.

## Interface
- DEPTH, 64: number of CAM entries; also the width of every match vector.
- KEY_W, 8: key width in bits.
- IDX_W, $clog2(DEPTH): entry index width (derived).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- wr_en  input  1  write one table entry.
- wr_addr  input  IDX_W  entry index to write.
- wr_data  input  KEY_W  key written; the entry's valid bit is set.
- clr  input  1  start a table clear.
- busy  output  1  clear in progress.
- cam_req  input  1  search request.
- xi  input  KEY_W  search key.
- xi_mv  output  DEPTH  search result; bit k = valid[k] && key[k]==xi.
- xi_mv_vld  output  1  one-cycle pulse qualifying xi_mv.
- sub_req  input  1  subtract request.
- xmax_mv  input  DEPTH  match vector of the maximum.
- xi_in_mv  input  DEPTH  match vector of the element.
- sub_mv  output  DEPTH  match vector of (key_max − key_i).
- sub_mv_vld  output  1  one-cycle pulse qualifying sub_mv.
- err_onehot  output  1  sticky: a subtract operand had no set bit.
- err_uflow  output  1  sticky: key_max < key_i was seen.

## Operation
- Reset clears every key to 0, every valid bit to 0, every output to 0, and the FSM to IDLE.
- The FSM has two states: IDLE and CLEAR.
  - IDLE → CLEAR when clr=1. busy goes high in the next cycle.
  - CLEAR invalidates 8 entries per cycle, advancing a 3-bit-wide block counter from 0 to DEPTH/8−1. After the last block it returns to IDLE and busy drops.
  - clr asserted while in CLEAR is ignored.
- While busy=1:
  - cam_req, sub_req and wr_en are dropped. No valid pulse is produced.
  - Pipeline stages already in flight complete normally.
- Search path (1 stage): xi_mv <= match(xi); xi_mv_vld <= cam_req && !busy.
- Subtract path (2 stages):
  - Stage 1:
    - Lowest-set-bit priority-encode xmax_mv → im and xi_in_mv → ii.
    - d = key[im] − key[ii] in KEY_W+1 bits.
    - If the borrow is set, d saturates to 0.
    - Register d and the flags.
  - Stage 2: sub_mv <= match(d); sub_mv_vld <= stage-1 valid.
  - A vector with more than one set bit is legal; only its lowest bit is used.
  - An all-zero operand uses index 0.
- Both paths have separate comparator arrays. cam_req and sub_req in the same cycle are both serviced.
- Write/search collision:
  - A write in cycle N takes effect at the end of cycle N.
  - A search or stage-1 read in cycle N sees the old contents.
- Keys compare as unsigned. Invalid entries never match, including key 0.

## Timing
- Search: request in cycle N → xi_mv and xi_mv_vld valid in cycle N+1. xi_mv holds until the next accepted cam_req; xi_mv_vld is low otherwise.
- Subtract: request in cycle N → sub_mv and sub_mv_vld valid in cycle N+2. The path is fully pipelined and accepts one request per cycle.
- Clear: clr in cycle N → busy is high in cycles N+1 … N+DEPTH/8 (8 cycles at DEPTH=64). Requests are accepted again from cycle N+DEPTH/8+1.
- Reset mid-operation aborts CLEAR and both pipelines immediately. No valid pulse follows reset release.

## Configuration
- STAR_CAM_ERR_EN defined:
  - err_onehot sets when an accepted sub_req has an all-zero xmax_mv or xi_in_mv.
  - err_uflow sets when stage 1 saturates.
  - Both flags are sticky until reset or clr.
- STAR_CAM_ERR_EN undefined:
  - Both error ports are tied to 0 and the flag logic is removed.
  - Saturation and index-0 fallback behaviour are unchanged.

## Test plan
- Write keys 5, 9, 5 to entries 0, 1, 2; cam_req xi=5 → cycle N+1: xi_mv=0x5, xi_mv_vld=1 for exactly one cycle.
- After reset with no writes, cam_req xi=0 → xi_mv=0, because invalid entries do not match.
- Keys: entry 3=40, entry 7=12, entry 10=28. sub_req with xmax_mv=1<<3 and xi_in_mv=1<<7 → cycle N+2: sub_mv=1<<10. Issue back-to-back requests on consecutive cycles → consecutive sub_mv_vld pulses.
- Operands swapped (key_max=12, key_i=40) → d=0 and sub_mv matches only valid entries with key 0. With STAR_CAM_ERR_EN: err_uflow=1 and it stays high.
- clr while entries are valid → busy high for exactly 8 cycles. A cam_req during busy gives no xi_mv_vld. A cam_req after busy drops gives xi_mv=0.
- wr_en entry 4=77 and cam_req xi=77 in the same cycle → xi_mv bit 4 = 0. Repeating the cam_req next cycle → bit 4 = 1.

Source files
------------

// File: rtl/star_cam_responder.sv
// CAM/SUB match-vector responder: key table with a search path (1 stage) and a
// saturating subtract path (2 stages). Define STAR_CAM_ERR_EN to enable the sticky error flags.
module star_cam_responder #(
  parameter int DEPTH = 64,
  parameter int KEY_W = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             clr,
  output logic             busy,
  input  logic             cam_req,
  input  logic [KEY_W-1:0] xi,
  output logic [DEPTH-1:0] xi_mv,
  output logic             xi_mv_vld,
  input  logic             sub_req,
  input  logic [DEPTH-1:0] xmax_mv,
  input  logic [DEPTH-1:0] xi_in_mv,
  output logic [DEPTH-1:0] sub_mv,
  output logic             sub_mv_vld,
  output logic             err_onehot,
  output logic             err_uflow
);

  localparam int NBLK  = DEPTH / 8;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [KEY_W-1:0] key_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [DEPTH-1:0] xi_mv_q, sub_mv_q;
  logic             xi_mv_vld_q, sub_mv_vld_q;
  logic             s1_vld_q;
  logic [KEY_W-1:0] s1_d_q;

  logic accept, cam_acc, sub_acc, wr_acc, clr_acc;
  assign accept  = (state_q == ST_IDLE);
  assign cam_acc = cam_req && accept;
  assign sub_acc = sub_req && accept;
  assign wr_acc  = wr_en && accept;
  assign clr_acc = clr && accept;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          blk_d   = '0;
        end
      end
      default: begin
        if (blk_q == BLK_W'(NBLK - 1)) state_d = ST_IDLE;
        else                           blk_d   = blk_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  // Writes land at the end of the cycle, so same-cycle searches see old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_acc && wr_addr == IDX_W'(i)) begin
          key_q[i]   <= wr_data;
          valid_q[i] <= 1'b1;
        end else if (state_q == ST_CLEAR && blk_q == BLK_W'(i / 8)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  logic [DEPTH-1:0] xi_hit, sub_hit;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign xi_hit[gi]  = valid_q[gi] && (key_q[gi] == xi);
    assign sub_hit[gi] = valid_q[gi] && (key_q[gi] == s1_d_q);
  end

  // Lowest set bit wins; an all-zero vector falls back to index 0.
  function automatic logic [IDX_W-1:0] lsb_idx(input logic [DEPTH-1:0] v);
    lsb_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = IDX_W'(i);
    end
  endfunction

  logic [IDX_W-1:0] im, ii;
  logic [KEY_W:0]   diff;
  assign im   = lsb_idx(xmax_mv);
  assign ii   = lsb_idx(xi_in_mv);
  assign diff = {1'b0, key_q[im]} - {1'b0, key_q[ii]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xi_mv_q      <= '0;
      xi_mv_vld_q  <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_d_q       <= '0;
      sub_mv_q     <= '0;
      sub_mv_vld_q <= 1'b0;
    end else begin
      xi_mv_vld_q <= cam_acc;
      if (cam_acc) xi_mv_q <= xi_hit;
      s1_vld_q <= sub_acc;
      if (sub_acc) s1_d_q <= diff[KEY_W] ? '0 : diff[KEY_W-1:0];
      sub_mv_vld_q <= s1_vld_q;
      if (s1_vld_q) sub_mv_q <= sub_hit;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign xi_mv      = xi_mv_q;
  assign xi_mv_vld  = xi_mv_vld_q;
  assign sub_mv     = sub_mv_q;
  assign sub_mv_vld = sub_mv_vld_q;

`ifdef STAR_CAM_ERR_EN
  logic err_onehot_q, err_uflow_q;
  // A new error in the same cycle as an accepted clr still sets the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_onehot_q <= 1'b0;
      err_uflow_q  <= 1'b0;
    end else begin
      if (clr_acc) begin
        err_onehot_q <= 1'b0;
        err_uflow_q  <= 1'b0;
      end
      if (sub_acc && (~|xmax_mv || ~|xi_in_mv)) err_onehot_q <= 1'b1;
      if (sub_acc && diff[KEY_W])               err_uflow_q  <= 1'b1;
    end
  end
  assign err_onehot = err_onehot_q;
  assign err_uflow  = err_uflow_q;
`else
  logic unused_clr_acc;
  assign unused_clr_acc = clr_acc;
  assign err_onehot     = 1'b0;
  assign err_uflow      = 1'b0;
`endif

endmodule

// File: tb/tb_star_cam_responder.sv
// Randomized bench for star_cam_responder against a table-level reference model.
module tb_star_cam_responder;
  localparam int DEPTH = 64;
  localparam int KEY_W = 8;
  localparam int IDX_W = 6;
`ifdef STAR_CAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [KEY_W-1:0] wr_data = '0;
  logic             clr = 1'b0;
  logic             busy;
  logic             cam_req = 1'b0;
  logic [KEY_W-1:0] xi = '0;
  logic [DEPTH-1:0] xi_mv;
  logic             xi_mv_vld;
  logic             sub_req = 1'b0;
  logic [DEPTH-1:0] xmax_mv = '0;
  logic [DEPTH-1:0] xi_in_mv = '0;
  logic [DEPTH-1:0] sub_mv;
  logic             sub_mv_vld;
  logic             err_onehot;
  logic             err_uflow;

  always #5 clk = ~clk;

  star_cam_responder #(.DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .busy(busy),
    .cam_req(cam_req), .xi(xi), .xi_mv(xi_mv), .xi_mv_vld(xi_mv_vld),
    .sub_req(sub_req), .xmax_mv(xmax_mv), .xi_in_mv(xi_in_mv),
    .sub_mv(sub_mv), .sub_mv_vld(sub_mv_vld),
    .err_onehot(err_onehot), .err_uflow(err_uflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the key table plus the visible results of each request.
  logic [7:0]  m_key [DEPTH];
  logic [63:0] m_val;
  int          m_clr_left, m_blk;
  logic [63:0] m_xi_mv, m_sub_mv;
  bit          m_xi_vld, m_sub_vld, m_s1_v, m_eo, m_eu;
  logic [7:0]  m_s1_d;

  function automatic logic [63:0] m_match(input logic [7:0] k);
    logic [63:0] r = '0;
    for (int i = 0; i < DEPTH; i++) r[i] = m_val[i] && (m_key[i] == k);
    return r;
  endfunction

  function automatic int lowest(input logic [63:0] v);
    for (int i = 0; i < DEPTH; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_key[i] = '0;
    m_val = '0; m_clr_left = 0; m_blk = 0;
    m_xi_mv = '0; m_sub_mv = '0; m_xi_vld = 0; m_sub_vld = 0;
    m_s1_v = 0; m_s1_d = '0; m_eo = 0; m_eu = 0;
  endtask

  task automatic model_edge();
    bit acc = (m_clr_left == 0);
    bit nxv, nsv, ns1v;
    logic [63:0] nxi = m_xi_mv;
    logic [63:0] nsub = m_sub_mv;
    logic [7:0] ns1d = m_s1_d;
    int a = 0, b = 0;
    nxv = cam_req && acc;
    if (nxv) nxi = m_match(xi);
    nsv = m_s1_v;
    if (m_s1_v) nsub = m_match(m_s1_d);
    ns1v = sub_req && acc;
    if (ns1v) begin
      a = int'(m_key[lowest(xmax_mv)]);
      b = int'(m_key[lowest(xi_in_mv)]);
      ns1d = (a >= b) ? 8'(a - b) : 8'd0;
    end
    if (ERR_EN) begin
      if (clr && acc) begin m_eo = 0; m_eu = 0; end
      if (ns1v && (xmax_mv == 0 || xi_in_mv == 0)) m_eo = 1;
      if (ns1v && a < b) m_eu = 1;
    end
    if (wr_en && acc) begin
      m_key[wr_addr] = wr_data;
      m_val[wr_addr] = 1'b1;
    end
    if (!acc) begin
      for (int j = 0; j < 8; j++) m_val[m_blk * 8 + j] = 1'b0;
      m_blk++;
      m_clr_left--;
    end else if (clr) begin
      m_clr_left = 8;
      m_blk = 0;
    end
    m_xi_mv = nxi; m_xi_vld = nxv; m_sub_mv = nsub; m_sub_vld = nsv;
    m_s1_v = ns1v; m_s1_d = ns1d;
  endtask

  task automatic compare();
    check("xi_mv_vld",  xi_mv_vld,  m_xi_vld);
    check("xi_mv",      xi_mv,      m_xi_mv);
    check("sub_mv_vld", sub_mv_vld, m_sub_vld);
    check("sub_mv",     sub_mv,     m_sub_mv);
    check("busy",       busy,       m_clr_left > 0);
    check("err_onehot", err_onehot, m_eo);
    check("err_uflow",  err_uflow,  m_eu);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    wr_en = 0; clr = 0; cam_req = 0; sub_req = 0;
  endtask

  task automatic write(input int addr, input int data);
    idle();
    wr_en = 1; wr_addr = IDX_W'(addr); wr_data = KEY_W'(data);
    cycle();
    idle();
  endtask

  function automatic logic [63:0] rand_mv();
    int r = $urandom_range(0, 9);
    if (r == 0) return 64'd0;
    if (r == 1) return {$urandom, $urandom};
    return 64'd1 << $urandom_range(0, 63);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    model_reset();
    repeat (3) cycle();
    check("rst_busy", busy, 0);
    check("rst_xi_mv", xi_mv, 0);
    reset = 0;

    // Empty table: key 0 must not match invalid entries.
    cam_req = 1; xi = 0; cycle(); idle();
    check("tp_inv0", xi_mv, 64'd0);
    check("tp_inv0_vld", xi_mv_vld, 1);

    write(0, 5); write(1, 9); write(2, 5);
    cam_req = 1; xi = 5; cycle(); idle();
    check("tp_xi5", xi_mv, 64'h5);
    check("tp_xi5_vld", xi_mv_vld, 1);
    cycle();
    check("tp_xi5_pulse", xi_mv_vld, 0);

    write(3, 40); write(7, 12); write(10, 28);
    sub_req = 1; xmax_mv = 64'd1 << 3; xi_in_mv = 64'd1 << 7;
    cycle();
    check("tp_sub_lat1", sub_mv_vld, 0);
    cycle(); idle();
    check("tp_sub_a", sub_mv, 64'd1 << 10);
    check("tp_sub_a_vld", sub_mv_vld, 1);
    cycle();
    check("tp_sub_b", sub_mv, 64'd1 << 10);
    check("tp_sub_b_vld", sub_mv_vld, 1);
    cycle();
    check("tp_sub_end", sub_mv_vld, 0);

    write(20, 0);
    sub_req = 1; xmax_mv = 64'd1 << 7; xi_in_mv = 64'd1 << 3;
    cycle(); idle(); cycle();
    check("tp_sat", sub_mv, 64'd1 << 20);
    check("tp_sat_uflow", err_uflow, ERR_EN);
    cycle(); cycle();
    check("tp_sat_sticky", err_uflow, ERR_EN);

    clr = 1; cycle(); idle();
    cam_req = 1; xi = 5;
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      cycle();
      check("tp_busy_novld", xi_mv_vld, 0);
    end
    check("tp_busy_len", 64'(nb), 64'd8);
    cycle(); idle();
    check("tp_after_clr", xi_mv, 64'd0);
    check("tp_after_clr_vld", xi_mv_vld, 1);
    check("tp_clr_uflow", err_uflow, 0);

    wr_en = 1; wr_addr = 4; wr_data = 77; cam_req = 1; xi = 77;
    cycle();
    check("tp_coll_old", xi_mv[4], 0);
    wr_en = 0;
    cycle(); idle();
    check("tp_coll_new", xi_mv[4], 1);

    for (int it = 0; it < 1500; it++) begin
      cam_req  = ($urandom_range(0, 2) == 0);
      xi       = KEY_W'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = IDX_W'($urandom_range(0, 63));
      wr_data  = KEY_W'($urandom_range(0, 15));
      sub_req  = ($urandom_range(0, 1) == 0);
      xmax_mv  = rand_mv();
      xi_in_mv = rand_mv();
      clr      = ($urandom_range(0, 80) == 0) || (it == 695);
      cycle();
      if (it == 700) begin
        reset = 1;
        model_reset();
        #1;
        compare();
        idle();
        cycle(); cycle();
        reset = 0;
      end
    end
    idle();
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
